// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game sequencer.
// Holds direction/state encodings, default board size and direction helpers.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  localparam int BOARD_W = 30;
  localparam int BOARD_H = 22;

  // up<->down and left<->right differ only in bit 0
  function automatic dir_t dir_opposite(dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  // keys = {up, down, left, right}; up has the highest priority
  function automatic dir_t dir_pick(logic [3:0] keys);
    dir_t d;
    if (keys[3])      d = DIR_UP;
    else if (keys[2]) d = DIR_DOWN;
    else if (keys[1]) d = DIR_LEFT;
    else              d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/snake_frame_divider.sv
// Counts rising edges of the frame marker and ticks every `divisor` frames.
// Ports: vga_clock, restart, refresh, enable, divisor[9:0] in; tick out.
module snake_frame_divider (
  input  logic       vga_clock,
  input  logic       restart,
  input  logic       refresh,
  input  logic       enable,
  input  logic [9:0] divisor,
  output logic       tick
);

  logic       refresh_q;
  logic       rise;
  logic [9:0] count;
  logic [9:0] count_nx;

  assign rise     = refresh & ~refresh_q;
  assign count_nx = count + 10'd1;
  // >= so a divisor of 0 behaves like 1 instead of never ticking
  assign tick     = enable & rise & (count_nx >= divisor);

  always_ff @(posedge vga_clock) begin
    if (restart) begin
      refresh_q <= 1'b0;
      count     <= '0;
    end else begin
      refresh_q <= refresh;
      if (!enable || tick)
        count <= '0;
      else if (rise)
        count <= count_nx;
    end
  end

endmodule

// File: rtl/snake_sequencer.sv
// Game sequencer: board clear sweep, frame-paced stepping, direction and length.
// Ports: vga_clock, restart, refresh, up/down/left/right_in, step_ack, collide,
//   ate in; step_req, step_dir[1:0], clr_en, clr_x/clr_y[4:0], dead, playing,
//   length[9:0] out. Define SNAKE_SEQ_SPEEDUP_EN to shorten steps as it grows.
module snake_sequencer
  import snake_pkg::*;
#(
  parameter int WIDTH    = BOARD_W,
  parameter int HEIGHT   = BOARD_H,
  parameter int BASE_DIV = 8,
  parameter int MIN_DIV  = 2
) (
  input  logic       vga_clock,
  input  logic       restart,
  input  logic       refresh,
  input  logic       up_in,
  input  logic       down_in,
  input  logic       left_in,
  input  logic       right_in,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  input  logic       collide,
  input  logic       ate,
  output logic       clr_en,
  output logic [4:0] clr_x,
  output logic [4:0] clr_y,
  output logic       dead,
  output logic       playing,
  output logic [9:0] length
);

  localparam logic [4:0] X_LAST = 5'(WIDTH - 1);
  localparam logic [4:0] Y_LAST = 5'(HEIGHT - 1);
  localparam logic [9:0] CELLS  = 10'(WIDTH * HEIGHT);
  localparam logic [9:0] BASE   = 10'(BASE_DIV);
  localparam logic [9:0] MIN    = 10'(MIN_DIV);

`ifdef SNAKE_SEQ_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  state_t     state;
  state_t     state_nx;
  dir_t       pend;
  dir_t       com;
  dir_t       pick;
  logic [3:0] keys;
  logic [3:0] keys_q;
  logic       any_key;
  logic       key_rise;
  logic       last_cell;
  logic       tick;
  logic       run_en;
  logic [9:0] shave;
  logic       floor_hit;
  logic [9:0] divisor;

  assign keys      = {up_in, down_in, left_in, right_in};
  assign any_key   = |keys;
  assign key_rise  = |(keys & ~keys_q);
  assign pick      = dir_pick(keys);
  assign last_cell = (clr_x == X_LAST) && (clr_y == Y_LAST);
  assign run_en    = (state == ST_RUN);

  // compare before subtracting so the divisor never wraps below MIN
  assign shave     = length >> 2;
  assign floor_hit = (shave + MIN) >= BASE;
  assign divisor   = !SPEEDUP  ? BASE :
                     floor_hit ? MIN  : BASE - shave;

  snake_frame_divider u_div (
    .vga_clock (vga_clock),
    .restart   (restart),
    .refresh   (refresh),
    .enable    (run_en),
    .divisor   (divisor),
    .tick      (tick)
  );

  always_ff @(posedge vga_clock) begin
    if (restart)
      state <= ST_CLEAR;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_CLEAR: if (last_cell) state_nx = ST_IDLE;
      ST_IDLE:  if (any_key)   state_nx = ST_RUN;
      ST_RUN:   if (tick)      state_nx = ST_STEP;
      ST_STEP:  if (step_ack)
                  state_nx = collide ? ST_DEAD : ST_RUN;
      ST_DEAD:  if (key_rise)  state_nx = ST_CLEAR;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  always_comb begin
    clr_en   = (state == ST_CLEAR);
    step_req = (state == ST_STEP);
    dead     = (state == ST_DEAD);
    playing  = (state == ST_RUN) || (state == ST_STEP);
    step_dir = com;
  end

  // sweep address wraps to (0,0) on the last cell so the next clear starts clean
  always_ff @(posedge vga_clock) begin
    if (restart) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_x == X_LAST) begin
        clr_x <= '0;
        clr_y <= (clr_y == Y_LAST) ? 5'd0 : clr_y + 5'd1;
      end else begin
        clr_x <= clr_x + 5'd1;
      end
    end
  end

  always_ff @(posedge vga_clock) begin
    if (restart) begin
      length <= 10'd1;
    end else if (state == ST_CLEAR || state == ST_IDLE) begin
      length <= 10'd1;
    end else if (state == ST_STEP && step_ack && !collide && ate) begin
      if (length < CELLS)
        length <= length + 10'd1;
    end
  end

  // a reversal would run the head into its own neck, so it is dropped
  always_ff @(posedge vga_clock) begin
    if (restart) begin
      pend   <= DIR_RIGHT;
      com    <= DIR_RIGHT;
      keys_q <= '0;
    end else begin
      keys_q <= keys;
      if (any_key && pick != dir_opposite(com))
        pend <= pick;
      if (state == ST_RUN && tick)
        com <= pend;
    end
  end

endmodule

// File: tb/tb_snake_sequencer.sv
// Randomized self-checking bench for snake_sequencer.
// Reference model tracks length, pending/committed direction and step pacing.
module tb_snake_sequencer;

  localparam int W     = 30;
  localparam int H     = 22;
  localparam int BASE  = 8;
  localparam int MIN   = 2;
  localparam int CELLS = W * H;

  logic       vga_clock = 1'b0;
  logic       restart   = 1'b1;
  logic       refresh   = 1'b0;
  logic       up_in     = 1'b0;
  logic       down_in   = 1'b0;
  logic       left_in   = 1'b0;
  logic       right_in  = 1'b0;
  logic       step_ack  = 1'b0;
  logic       collide   = 1'b0;
  logic       ate       = 1'b0;
  logic       step_req;
  logic [1:0] step_dir;
  logic       clr_en;
  logic [4:0] clr_x;
  logic [4:0] clr_y;
  logic       dead;
  logic       playing;
  logic [9:0] length;

  int n_cmp = 0;
  int n_bad = 0;
  int m_len = 1;
  int m_pend = 3;
  int m_com = 3;

  always #5 vga_clock = ~vga_clock;

  snake_sequencer #(
    .WIDTH(W), .HEIGHT(H), .BASE_DIV(BASE), .MIN_DIV(MIN)
  ) dut (
    .vga_clock (vga_clock),
    .restart   (restart),
    .refresh   (refresh),
    .up_in     (up_in),
    .down_in   (down_in),
    .left_in   (left_in),
    .right_in  (right_in),
    .step_req  (step_req),
    .step_dir  (step_dir),
    .step_ack  (step_ack),
    .collide   (collide),
    .ate       (ate),
    .clr_en    (clr_en),
    .clr_x     (clr_x),
    .clr_y     (clr_y),
    .dead      (dead),
    .playing   (playing),
    .length    (length)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clock);
    #1;
  endtask

  function automatic int opp(int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // frames per step for the current model length
  function automatic int exp_div();
    int d;
    d = BASE;
`ifdef SNAKE_SEQ_SPEEDUP_EN
    d = BASE - m_len / 4;
    if (d < MIN) d = MIN;
`endif
    return d;
  endfunction

  // d = {up, down, left, right}
  task automatic set_dirs(input bit [3:0] d);
    int ch;
    {up_in, down_in, left_in, right_in} = d;
    if (d != 4'b0) begin
      ch = d[3] ? 0 : d[2] ? 1 : d[1] ? 2 : 3;
      if (ch != opp(m_com)) m_pend = ch;
    end
  endtask

  task automatic sweep_chk();
    for (int i = 0; i < CELLS; i++) begin
      chk("clr_en", clr_en, 1);
      chk("clr_addr", clr_y * 32 + clr_x, (i / W) * 32 + (i % W));
      tick();
    end
    chk("sweep_end", clr_en, 0);
    chk("idle_len", length, 1);
    chk("idle_play", playing, 0);
    chk("idle_dead", dead, 0);
  endtask

  // one RUN->STEP->ack round; kill restarts while STEP is pending
  task automatic do_step(input bit fast, input bit [3:0] dirs,
                         input bit a_ate, input bit a_col, input bit kill);
    int  edges;
    int  k;
    int  gap;
    bit  got;
    edges = 0;
    got   = 0;
    while (!got && edges < 40) begin
      refresh = 1'b1;
      tick();
      edges++;
      refresh = 1'b0;
      if (step_req) got = 1;
      if (!got) begin
        gap = fast ? 1 : $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          if (!fast && $urandom_range(0, 3) == 0) begin
            step_ack = 1'b1;
            collide  = 1'b1;
            ate      = 1'b1;
          end
          tick();
          step_ack = 1'b0;
          collide  = 1'b0;
          ate      = 1'b0;
          if (step_req) got = 1;
        end
      end
    end
    chk("step_seen", got, 1);
    chk("frames", edges, exp_div());
    m_com = m_pend;
    chk("step_dir", step_dir, m_com);
    if (!got) return;
    if (kill) begin
      set_dirs(4'b0);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      m_len  = 1;
      m_pend = 3;
      m_com  = 3;
      chk("kill_req", step_req, 0);
      chk("kill_clr", clr_en, 1);
      chk("kill_addr", clr_y * 32 + clr_x, 0);
      chk("kill_len", length, 1);
      chk("kill_dir", step_dir, 3);
      chk("kill_play", playing, 0);
      return;
    end
    if (!fast) set_dirs(dirs);
    k = fast ? 0 : $urandom_range(0, 4);
    for (int i = 0; i < k; i++) begin
      refresh = (i % 2 == 0);
      tick();
      chk("req_hold", step_req, 1);
      chk("dir_hold", step_dir, m_com);
    end
    refresh  = 1'b0;
    step_ack = 1'b1;
    ate      = a_ate;
    collide  = a_col;
    tick();
    step_ack = 1'b0;
    ate      = 1'b0;
    collide  = 1'b0;
    if (a_col) begin
      chk("dead", dead, 1);
      chk("dead_play", playing, 0);
      chk("dead_len", length, m_len);
    end else begin
      if (a_ate && m_len < CELLS) m_len++;
      chk("run_play", playing, 1);
      chk("len", length, m_len);
    end
  endtask

  initial begin
    tick();
    chk("rst_clr_en", clr_en, 1);
    chk("rst_addr", clr_y * 32 + clr_x, 0);
    chk("rst_req", step_req, 0);
    chk("rst_dir", step_dir, 3);
    chk("rst_dead", dead, 0);
    chk("rst_play", playing, 0);
    chk("rst_len", length, 1);
    restart = 1'b0;
    sweep_chk();

    repeat (3) begin
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      tick();
    end
    chk("idle_hold", playing, 0);
    set_dirs(4'b0001);
    tick();
    set_dirs(4'b0000);
    chk("start_play", playing, 1);

    do_step(0, 4'b0010, 0, 0, 0);
    do_step(0, 4'b1000, 1, 0, 0);
    do_step(0, 4'b0000, 1, 0, 0);
    for (int s = 0; s < 40; s++)
      do_step(0, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) < 7), 0, 0);
    repeat (CELLS) do_step(1, 4'b0, 1, 0, 0);
    chk("sat_len", length, CELLS);

    do_step(0, 4'($urandom_range(0, 15)), 1, 1, 0);
    set_dirs(4'b0000);
    tick();
    chk("dead_stay", dead, 1);
    set_dirs(4'b0100);
    tick();
    chk("reclr_en", clr_en, 1);
    chk("reclr_addr", clr_y * 32 + clr_x, 0);
    chk("reclr_dead", dead, 0);

    repeat ($urandom_range(50, 600)) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_pend = 3;
    m_com  = 3;
    set_dirs(4'b0000);
    sweep_chk();

    set_dirs(4'($urandom_range(1, 15)));
    tick();
    set_dirs(4'b0000);
    chk("start2_play", playing, 1);
    do_step(0, 4'b0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
